// File: rtl/nvram_uploader.sv
// ---------------------------------------------------------------------------
// nvram_uploader
//
// Serves HPS upload (save) requests on the ioctl bus by reading a dual-port
// game NVRAM / hiscore RAM back one byte at a time. This is the read-direction
// counterpart of the ROM/DIP download path. The core CPU is paused for the
// whole session so that the saved snapshot is coherent. ioctl_wait is held
// while each RAM read is in flight.
//
// Optional feature (compile-time macro NVRAM_CHECKSUM_EN):
//   An 8-bit running sum of every in-range byte delivered to the HPS is kept.
//   A read at exactly address 2^AW returns its two's complement, so that
//   (sum + checksum) == 0 mod 256. Without the macro that address returns
//   8'hFF like any other out-of-range address, and no sum register exists.
//
// Parameters:
//   AW           RAM address width; the image is 2^AW bytes.
//   UPLOAD_INDEX ioctl_index value that selects this block.
//   RD_LATENCY   cycles from ram_rd to valid ram_do, legal range 1..3.
//
// Ports:
//   clk_sys      in   system clock
//   reset        in   synchronous, active-high reset
//   ioctl_upload in   HPS upload session active
//   ioctl_index  in   upload target index
//   ioctl_rd     in   single-cycle read strobe from hps_io
//   ioctl_addr   in   byte address of the read (25 bits)
//   ioctl_din    out  read data returned to hps_io
//   ioctl_wait   out  stall to HPS, data not ready while high
//   pause_req    out  request to halt the core CPU
//   pause_ack    in   core CPU is halted
//   ram_addr     out  RAM read address
//   ram_rd       out  RAM read strobe, one cycle
//   ram_do       in   RAM read data
//   busy         out  upload session in progress
//   done         out  one-cycle pulse when a session ends
// ---------------------------------------------------------------------------
module nvram_uploader #(
  parameter int          AW           = 10,
  parameter logic [7:0]  UPLOAD_INDEX = 8'd4,
  parameter int          RD_LATENCY   = 1
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_upload,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_rd,
  input  logic [24:0]   ioctl_addr,
  output logic [7:0]    ioctl_din,
  output logic          ioctl_wait,
  output logic          pause_req,
  input  logic          pause_ack,
  output logic [AW-1:0] ram_addr,
  output logic          ram_rd,
  input  logic [7:0]    ram_do,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    IDLE,
    PAUSE,
    READY,
    FETCH,
    DONE
  } state_t;

  // First byte address past the image, compared against the full 25-bit
  // ioctl_addr so high address bits can never alias into the RAM.
  localparam logic [24:0] IMG_SIZE = 25'd1 << AW;

  // FETCH counts 0..RD_LATENCY starting in the ram_rd cycle; ram_do is
  // valid when the count reaches RD_LATENCY.
  localparam logic [1:0]  LAT_LAST = 2'(RD_LATENCY);

  state_t        state_q, state_d;
  logic          upload_q;
  logic          rise, fall, end_session;
  logic          in_range;
  logic [1:0]    cnt_q, cnt_d;
  logic          oor_q, oor_d;
  logic [7:0]    din_d;
  logic          wait_d, pause_d, ram_rd_d, busy_d, done_d;
  logic [AW-1:0] ram_addr_d;
`ifdef NVRAM_CHECKSUM_EN
  logic [7:0]    sum_q, sum_d;
  logic          sum_sel_q, sum_sel_d;
  logic          is_sum_addr;
`endif

  assign rise        = ioctl_upload & ~upload_q;
  assign fall        = ~ioctl_upload & upload_q;
  assign end_session = fall && (state_q == PAUSE || state_q == READY ||
                                state_q == FETCH);
  assign in_range    = ioctl_addr < IMG_SIZE;
`ifdef NVRAM_CHECKSUM_EN
  assign is_sum_addr = ioctl_addr == IMG_SIZE;
`endif

  // Next-state and next-output logic. All outputs are registered, so this
  // block computes the values they take after the coming clock edge.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    oor_d      = oor_q;
    din_d      = ioctl_din;
    wait_d     = ioctl_wait;
    pause_d    = pause_req;
    ram_addr_d = ram_addr;
    ram_rd_d   = 1'b0;
    busy_d     = busy;
    done_d     = 1'b0;
`ifdef NVRAM_CHECKSUM_EN
    sum_d      = sum_q;
    sum_sel_d  = sum_sel_q;
`endif

    if (end_session) begin
      // Upload dropped: abandon any fetch without touching ioctl_din.
      state_d = DONE;
      done_d  = 1'b1;
      pause_d = 1'b0;
      wait_d  = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise && ioctl_index == UPLOAD_INDEX) begin
            state_d = PAUSE;
            pause_d = 1'b1;
            wait_d  = 1'b1;
            busy_d  = 1'b1;
`ifdef NVRAM_CHECKSUM_EN
            sum_d   = 8'd0;
`endif
          end
        end

        PAUSE: begin
          if (pause_ack) begin
            state_d = READY;
            wait_d  = 1'b0;
          end
        end

        READY: begin
          // pause_ack is deliberately not looked at here: once the CPU has
          // acknowledged, the session keeps it paused until upload ends.
          if (ioctl_rd) begin
            state_d = FETCH;
            wait_d  = 1'b1;
            cnt_d   = 2'd0;
            oor_d   = ~in_range;
            if (in_range) begin
              ram_addr_d = ioctl_addr[AW-1:0];
              ram_rd_d   = 1'b1;
            end
`ifdef NVRAM_CHECKSUM_EN
            sum_sel_d = is_sum_addr;
`endif
          end
        end

        FETCH: begin
          if (oor_q) begin
            state_d = READY;
            wait_d  = 1'b0;
`ifdef NVRAM_CHECKSUM_EN
            din_d   = sum_sel_q ? (8'd0 - sum_q) : 8'hFF;
`else
            din_d   = 8'hFF;
`endif
          end else if (cnt_q == LAT_LAST) begin
            state_d = READY;
            wait_d  = 1'b0;
            din_d   = ram_do;
`ifdef NVRAM_CHECKSUM_EN
            sum_d   = sum_q + ram_do;
`endif
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end

        DONE: begin
          state_d = IDLE;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and output registers. The upload edge detector is frozen during
  // DONE so that an upload re-asserted right after a falling edge still
  // appears as a rising edge once the FSM is back in IDLE.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= IDLE;
      upload_q   <= 1'b0;
      cnt_q      <= 2'd0;
      oor_q      <= 1'b0;
      ioctl_din  <= 8'd0;
      ioctl_wait <= 1'b0;
      pause_req  <= 1'b0;
      ram_addr   <= '0;
      ram_rd     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef NVRAM_CHECKSUM_EN
      sum_q      <= 8'd0;
      sum_sel_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      if (state_q != DONE) begin
        upload_q <= ioctl_upload;
      end
      cnt_q      <= cnt_d;
      oor_q      <= oor_d;
      ioctl_din  <= din_d;
      ioctl_wait <= wait_d;
      pause_req  <= pause_d;
      ram_addr   <= ram_addr_d;
      ram_rd     <= ram_rd_d;
      busy       <= busy_d;
      done       <= done_d;
`ifdef NVRAM_CHECKSUM_EN
      sum_q      <= sum_d;
      sum_sel_q  <= sum_sel_d;
`endif
    end
  end

endmodule

// File: tb/tb_nvram_uploader.sv
// ---------------------------------------------------------------------------
// tb_nvram_uploader
//
// Self-checking bench for nvram_uploader (AW=10, RD_LATENCY=1). A behavioural
// RAM with the configured read latency is attached; expected read data,
// wait timing and the running checksum are derived from the RAM contents and
// the upload protocol rules. Build with +define+NVRAM_CHECKSUM_EN to check
// the checksum feature instead of the plain 8'hFF response at address 2^AW.
// ---------------------------------------------------------------------------
module tb_nvram_uploader;

  localparam int          AW  = 10;
  localparam int          LAT = 1;
  localparam logic [7:0]  IDX = 8'd4;
  localparam logic [24:0] IMG = 25'd1 << AW;

  logic          clk_sys = 1'b0;
  logic          reset = 1'b1;
  logic          ioctl_upload = 1'b0;
  logic [7:0]    ioctl_index = 8'd0;
  logic          ioctl_rd = 1'b0;
  logic [24:0]   ioctl_addr = 25'd0;
  logic [7:0]    ioctl_din;
  logic          ioctl_wait;
  logic          pause_req;
  logic          pause_ack = 1'b0;
  logic [AW-1:0] ram_addr;
  logic          ram_rd;
  logic [7:0]    ram_do;
  logic          busy;
  logic          done;

  int checks = 0;
  int failures = 0;

  logic [7:0] mem [0:(1<<AW)-1];
  logic [7:0] pipe [0:LAT-1];
  logic [7:0] model_din = 8'd0;
  logic [7:0] model_sum = 8'd0;

  nvram_uploader #(
    .AW(AW),
    .UPLOAD_INDEX(IDX),
    .RD_LATENCY(LAT)
  ) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .ioctl_upload(ioctl_upload),
    .ioctl_index(ioctl_index),
    .ioctl_rd(ioctl_rd),
    .ioctl_addr(ioctl_addr),
    .ioctl_din(ioctl_din),
    .ioctl_wait(ioctl_wait),
    .pause_req(pause_req),
    .pause_ack(pause_ack),
    .ram_addr(ram_addr),
    .ram_rd(ram_rd),
    .ram_do(ram_do),
    .busy(busy),
    .done(done)
  );

  always #5 clk_sys = ~clk_sys;

  // RAM with LAT cycles of read latency; garbage is shifted in on cycles
  // without a read so that a mistimed capture shows up as wrong data.
  always @(posedge clk_sys) begin
    pipe[0] <= ram_rd ? mem[ram_addr] : 8'hEE;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign ram_do = pipe[LAT-1];

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  // One ioctl read issued from READY; checks every cycle until the byte
  // appears, then updates the model's held byte and running sum.
  task automatic read_and_check(input logic [24:0] addr);
    logic [7:0] exp;
    bit         ram_acc;
    int         lat;
    ram_acc = addr < IMG;
    if (ram_acc) exp = mem[addr[AW-1:0]];
    else if (addr == IMG) begin
`ifdef NVRAM_CHECKSUM_EN
      exp = 8'd0 - model_sum;
`else
      exp = 8'hFF;
`endif
    end else exp = 8'hFF;
    lat = ram_acc ? 2 + LAT : 2;
    ioctl_addr = addr;
    ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    ioctl_addr = 25'($urandom);
    for (int c = 1; c <= lat; c++) begin
      if (c > 1) tick();
      checks++;
      if (ioctl_wait !== (c < lat)) begin
        failures++;
        $display("[TB] FAIL rd_wait addr=%h cyc=%0d: got %b expected %b", addr, c, ioctl_wait, (c < lat));
      end
      checks++;
      if (ioctl_din !== ((c < lat) ? model_din : exp)) begin
        failures++;
        $display("[TB] FAIL rd_din addr=%h cyc=%0d: got %h expected %h", addr, c, ioctl_din, (c < lat) ? model_din : exp);
      end
      checks++;
      if (ram_rd !== (ram_acc && c == 1)) begin
        failures++;
        $display("[TB] FAIL rd_ram_rd addr=%h cyc=%0d: got %b expected %b", addr, c, ram_rd, (ram_acc && c == 1));
      end
      if (ram_acc && c == 1) begin
        checks++;
        if (ram_addr !== addr[AW-1:0]) begin
          failures++;
          $display("[TB] FAIL rd_ram_addr: got %h expected %h", ram_addr, addr[AW-1:0]);
        end
      end
      checks++;
      if ({pause_req, busy, done} !== 3'b110) begin
        failures++;
        $display("[TB] FAIL rd_session addr=%h cyc=%0d: got %b expected 110", addr, c, {pause_req, busy, done});
      end
    end
    model_din = exp;
    if (ram_acc) model_sum = model_sum + exp;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({ioctl_din, ioctl_wait, pause_req, ram_addr, ram_rd, busy, done} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got din=%h wait=%b pause=%b addr=%h rd=%b busy=%b done=%b expected all 0",
               ioctl_din, ioctl_wait, pause_req, ram_addr, ram_rd, busy, done);
    end
    reset = 1'b0;
    tick();
    checks++;
    if ({ioctl_din, ioctl_wait, pause_req, ram_rd, busy, done} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_idle: got din=%h wait=%b pause=%b rd=%b busy=%b done=%b expected all 0",
               ioctl_din, ioctl_wait, pause_req, ram_rd, busy, done);
    end
    model_din = 8'd0;
  endtask

  task automatic test_pause_handshake();
    ioctl_index = IDX;
    pause_ack = 1'b0;
    ioctl_upload = 1'b1;
    tick();
    model_sum = 8'd0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({pause_req, ioctl_wait, busy, done, ram_rd} !== 5'b11100 || ioctl_din !== model_din) begin
        failures++;
        $display("[TB] FAIL pause_hold cyc=%0d: got pause/wait/busy/done/rd=%b din=%h expected 11100 din=%h",
                 i, {pause_req, ioctl_wait, busy, done, ram_rd}, ioctl_din, model_din);
      end
      // A read strobe before the CPU is halted must be ignored.
      if (i == 4) begin
        ioctl_addr = 25'd3;
        ioctl_rd = 1'b1;
      end
      tick();
      ioctl_rd = 1'b0;
    end
    pause_ack = 1'b1;
    tick();
    checks++;
    if ({pause_req, ioctl_wait, busy, ram_rd} !== 4'b1010) begin
      failures++;
      $display("[TB] FAIL pause_ack_ready: got pause/wait/busy/rd=%b expected 1010", {pause_req, ioctl_wait, busy, ram_rd});
    end
  endtask

  task automatic test_in_range_reads();
    read_and_check(25'd3);
    for (int i = 0; i < 15; i++) read_and_check(25'($urandom_range(0, (1 << AW) - 1)));
    read_and_check(IMG - 25'd1);
  endtask

  task automatic test_out_of_range();
    read_and_check(25'h1FFFF);
    read_and_check(25'h1000003);
    read_and_check(25'h1FFFFFF);
    read_and_check(IMG + 25'd1);
    for (int i = 0; i < 5; i++) begin
      read_and_check(25'($urandom_range(0, (1 << AW) - 1)));
      read_and_check(IMG + 25'd1 + 25'($urandom_range(0, 32'h1FFFFFF - 32'(IMG) - 1)));
    end
    read_and_check(IMG);
  endtask

  task automatic test_ack_drop();
    pause_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({pause_req, ioctl_wait, busy} !== 3'b101) begin
        failures++;
        $display("[TB] FAIL ack_drop cyc=%0d: got pause/wait/busy=%b expected 101", i, {pause_req, ioctl_wait, busy});
      end
    end
    read_and_check(25'($urandom_range(0, (1 << AW) - 1)));
    pause_ack = 1'b1;
  endtask

  task automatic test_abort();
    int done_cnt;
    ioctl_addr = 25'd7;
    ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    ioctl_upload = 1'b0;
    tick();
    checks++;
    if ({done, pause_req, busy, ioctl_wait} !== 4'b1000 || ioctl_din !== model_din) begin
      failures++;
      $display("[TB] FAIL abort_done: got done/pause/busy/wait=%b din=%h expected 1000 din=%h",
               {done, pause_req, busy, ioctl_wait}, ioctl_din, model_din);
    end
    done_cnt = done ? 1 : 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) done_cnt++;
      checks++;
      if ({pause_req, busy, ioctl_wait, ram_rd} !== 4'b0000 || ioctl_din !== model_din) begin
        failures++;
        $display("[TB] FAIL abort_idle cyc=%0d: got pause/busy/wait/rd=%b din=%h expected 0000 din=%h",
                 i, {pause_req, busy, ioctl_wait, ram_rd}, ioctl_din, model_din);
      end
    end
    checks++;
    if (done_cnt !== 1) begin
      failures++;
      $display("[TB] FAIL abort_done_count: got %0d expected 1", done_cnt);
    end
  endtask

  task automatic test_wrong_index();
    ioctl_index = 8'd2;
    pause_ack = 1'b1;
    ioctl_upload = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ioctl_rd = (i % 3 == 1);
      ioctl_addr = 25'($urandom_range(0, (1 << AW) - 1));
      tick();
      ioctl_rd = 1'b0;
      checks++;
      if ({pause_req, ioctl_wait, ram_rd, done, busy} !== 5'b00000 || ioctl_din !== model_din) begin
        failures++;
        $display("[TB] FAIL wrong_index cyc=%0d: got pause/wait/rd/done/busy=%b din=%h expected 00000 din=%h",
                 i, {pause_req, ioctl_wait, ram_rd, done, busy}, ioctl_din, model_din);
      end
    end
    ioctl_upload = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (done !== 1'b0) begin
        failures++;
        $display("[TB] FAIL wrong_index_done cyc=%0d: got %b expected 0", i, done);
      end
    end
    ioctl_index = IDX;
  endtask

  task automatic test_back_to_back();
    ioctl_upload = 1'b1;
    tick();
    tick();
    model_sum = 8'd0;
    checks++;
    if ({pause_req, ioctl_wait, busy} !== 3'b101) begin
      failures++;
      $display("[TB] FAIL b2b_first_ready: got pause/wait/busy=%b expected 101", {pause_req, ioctl_wait, busy});
    end
    ioctl_upload = 1'b0;
    tick();
    checks++;
    if ({done, pause_req, busy} !== 3'b100) begin
      failures++;
      $display("[TB] FAIL b2b_done: got done/pause/busy=%b expected 100", {done, pause_req, busy});
    end
    ioctl_upload = 1'b1;
    tick();
    checks++;
    if ({done, pause_req, busy} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL b2b_idle: got done/pause/busy=%b expected 000", {done, pause_req, busy});
    end
    tick();
    model_sum = 8'd0;
    checks++;
    if ({pause_req, ioctl_wait, busy, done} !== 4'b1110) begin
      failures++;
      $display("[TB] FAIL b2b_restart: got pause/wait/busy/done=%b expected 1110", {pause_req, ioctl_wait, busy, done});
    end
    tick();
    checks++;
    if ({pause_req, ioctl_wait, busy} !== 3'b101) begin
      failures++;
      $display("[TB] FAIL b2b_ready: got pause/wait/busy=%b expected 101", {pause_req, ioctl_wait, busy});
    end
  endtask

  task automatic test_checksum();
    for (int a = 0; a < 4; a++) read_and_check(25'(a));
    read_and_check(IMG);
    read_and_check(25'd0);
    read_and_check(IMG);
    read_and_check(IMG + 25'd1);
  endtask

  task automatic test_reset_mid_session();
    ioctl_addr = 25'd5;
    ioctl_rd = 1'b1;
    tick();
    ioctl_rd = 1'b0;
    reset = 1'b1;
    ioctl_upload = 1'b0;
    tick();
    model_din = 8'd0;
    checks++;
    if ({ioctl_din, ioctl_wait, pause_req, ram_addr, ram_rd, busy, done} !== '0) begin
      failures++;
      $display("[TB] FAIL midreset_outputs: got din=%h wait=%b pause=%b addr=%h rd=%b busy=%b done=%b expected all 0",
               ioctl_din, ioctl_wait, pause_req, ram_addr, ram_rd, busy, done);
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({done, busy, pause_req} !== 3'b000 || ioctl_din !== model_din) begin
        failures++;
        $display("[TB] FAIL midreset_idle cyc=%0d: got done/busy/pause=%b din=%h expected 000 din=%h",
                 i, {done, busy, pause_req}, ioctl_din, model_din);
      end
    end
  endtask

  initial begin
    for (int n = 0; n < (1 << AW); n++) mem[n] = 8'(n) ^ 8'h5A;
    $display("[TB] nvram_uploader bench start");
    test_reset();
    test_pause_handshake();
    test_in_range_reads();
    test_out_of_range();
    test_ack_drop();
    test_abort();
    test_wrong_index();
    test_back_to_back();
    test_checksum();
    test_reset_mid_session();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nvram_uploader.md
Name: nvram_uploader

Overview:
- Serves HPS upload (save) requests on the ioctl bus, reading back game NVRAM/hiscore RAM byte by byte. It is the read-direction counterpart of the ROM/DIP download path.
- Sits between hps_io and a dual-port game RAM in the emu top.
- Pauses the core CPU for the whole upload so the snapshot is coherent.
- Holds ioctl_wait while each RAM read is in flight.

Parameters:
- AW, 10: RAM address width; the image size is 2^AW bytes.
- UPLOAD_INDEX, 8'd4: ioctl_index value that selects this block.
- RD_LATENCY, 1: cycles from ram_rd to valid ram_do; legal range 1..3.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ioctl_upload  in  1  HPS upload session active.
- ioctl_index  in  8  upload target index.
- ioctl_rd  in  1  single-cycle read strobe from hps_io.
- ioctl_addr  in  25  byte address of the read.
- ioctl_din  out  8  read data returned to hps_io.
- ioctl_wait  out  1  stall to HPS; data is not ready while high.
- pause_req  out  1  request to halt the core CPU.
- pause_ack  in  1  core CPU is halted.
- ram_addr  out  AW  RAM read address.
- ram_rd  out  1  RAM read strobe, one cycle.
- ram_do  in  8  RAM read data.
- busy  out  1  upload session in progress.
- done  out  1  one-cycle pulse when a session ends.

Behaviour:
- Reset: FSM goes to IDLE. ioctl_din=0, ioctl_wait=0, pause_req=0, ram_addr=0, ram_rd=0, busy=0, done=0. Reset mid-session aborts the session with no done pulse.
- Session start: ioctl_upload rising edge (registered compare) with ioctl_index==UPLOAD_INDEX. Rising edges with any other index are ignored; the block stays IDLE for that whole session.
- States: IDLE, PAUSE, READY, FETCH, DONE.
- IDLE -> PAUSE on a valid start. PAUSE sets pause_req=1, ioctl_wait=1, busy=1.
- PAUSE -> READY on the first cycle pause_ack=1; ioctl_wait drops in that transition.
- READY: ioctl_wait=0. pause_req stays high for the whole session; a pause_ack drop while in READY is ignored.
- READY, ioctl_rd=1 at cycle T: latch ioctl_addr.
- In-range address (ioctl_addr < 2^AW):
  - T+1: ram_addr=ioctl_addr[AW-1:0], ram_rd=1 (one cycle only), ioctl_wait=1; state is FETCH.
  - ram_do is captured RD_LATENCY cycles after the ram_rd cycle.
  - T+2+RD_LATENCY: ioctl_din=captured byte, ioctl_wait=0, state back to READY.
- Out-of-range address (>= 2^AW): no RAM access. T+1: ioctl_wait=1. T+2: ioctl_din=8'hFF, ioctl_wait=0.
- ioctl_rd in any state other than READY is ignored (protocol violation), with no side effects.
- ioctl_din holds its last value between reads.
- Session end: ioctl_upload falling edge from PAUSE, READY or FETCH -> DONE.
  - A fetch in progress is abandoned and ioctl_din is not updated.
  - DONE lasts one cycle: done=1, pause_req=0, ioctl_wait=0, busy=0; then IDLE.
- Upload falling and rising in adjacent cycles: DONE completes first; the new rising edge is detected from IDLE.
- Address compare uses the full 25-bit ioctl_addr; upper bits are never truncated before the range check.

Optional Feature:
- Macro: NVRAM_CHECKSUM_EN.
- When defined:
  - An 8-bit running sum, cleared on entry to PAUSE, adds every in-range byte delivered to ioctl_din (mod 256).
  - A read at exactly address 2^AW returns the two's complement of the sum (sum + checksum == 0 mod 256), with out-of-range timing.
  - Addresses above 2^AW return 8'hFF.
  - Re-reading an address adds it to the sum again.
- When undefined: address 2^AW returns 8'hFF and no sum register exists.

Test Plan:
- Reset with upload idle -> all outputs 0. Assert ioctl_upload with index 4, hold pause_ack=0 for 10 cycles -> pause_req=1, ioctl_wait=1, busy=1 throughout. Raise pause_ack -> ioctl_wait=0 on the next cycle.
- RAM preloaded addr n = n^8'h5A, RD_LATENCY=1. ioctl_rd at addr 3 at cycle T -> ram_rd only at T+1 with ram_addr=3; ioctl_wait high at T+1..T+2; ioctl_din=8'h59 and wait=0 at T+3.
- Read addr 25'h1FFFF (AW=10) -> no ram_rd, ioctl_din=8'hFF, wait high for exactly 1 cycle.
- Drop ioctl_upload one cycle after ioctl_rd to addr 7 -> ioctl_din unchanged, done pulses once, pause_req=0, busy=0, FSM idle.
- ioctl_upload with index 2 plus ioctl_rd strobes -> pause_req, ioctl_wait, ram_rd and done all stay 0.
- NVRAM_CHECKSUM_EN, AW=2, RAM={8'h01,8'h02,8'h03,8'h04}: read addr 0..3 then addr 4 -> addr 4 returns 8'hF6. Without the macro -> addr 4 returns 8'hFF.
